// File: rtl/reg_select_sequencer.sv
// Walks a binary index from a start value for N beats, presenting it both binary and one-hot.
// Optional REGSEL_SKIP_ZERO_EN: index 0 is never emitted and the count clamp drops to OUT_W-1.
module reg_select_sequencer #(
  parameter  int SEL_W = 4,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [SEL_W:0]   in_count,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic [SEL_W-1:0] out_index,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {IDLE, EMIT} state_t;

`ifdef REGSEL_SKIP_ZERO_EN
  localparam logic [SEL_W:0] MAX_CNT = (SEL_W+1)'(OUT_W - 1);
`else
  localparam logic [SEL_W:0] MAX_CNT = (SEL_W+1)'(OUT_W);
`endif

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W:0]   rem_q, rem_d;
  logic             dir_q, dir_d;

  logic [SEL_W:0]   eff_cnt;
  logic [SEL_W-1:0] start_idx;
  logic [SEL_W-1:0] step_idx;

  // Zero counts mean one beat; oversized counts saturate at one full sweep.
  always_comb begin
    eff_cnt = in_count;
    if (in_count == '0)
      eff_cnt = (SEL_W+1)'(1);
    else if (in_count > MAX_CNT)
      eff_cnt = MAX_CNT;
  end

  always_comb begin
    start_idx = in_sel;
    step_idx  = dir_q ? (idx_q - SEL_W'(1)) : (idx_q + SEL_W'(1));
`ifdef REGSEL_SKIP_ZERO_EN
    // Landing on zero hops one more position in the walk direction, same edge.
    if (in_sel == '0)
      start_idx = in_dir ? {SEL_W{1'b1}} : SEL_W'(1);
    if (step_idx == '0)
      step_idx = dir_q ? {SEL_W{1'b1}} : SEL_W'(1);
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          idx_d   = start_idx;
          rem_d   = eff_cnt;
          dir_d   = in_dir;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (rem_q == (SEL_W+1)'(1)) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            idx_d = step_idx;
            rem_d = rem_q - (SEL_W+1)'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_index = idx_q;
  assign out_last  = out_valid && (rem_q == (SEL_W+1)'(1));

  always_comb begin
    out_onehot = '0;
    if (out_valid)
      out_onehot[idx_q] = 1'b1;
  end

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Bench for reg_select_sequencer: directed scenarios plus randomized requests checked
// against a queue of expected beat indices computed from the sweep rules.
module tb_reg_select_sequencer;
  localparam int SEL_W = 4;
  localparam int OUT_W = 16;
`ifdef REGSEL_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [SEL_W:0]   in_count;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic [SEL_W-1:0] out_index;
  logic             out_last;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int q[$];

  reg_select_sequencer #(.SEL_W(SEL_W)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_count(in_count), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
    .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fix0(input int idx, input int dir);
    if (SKIP && idx == 0) return (dir != 0) ? OUT_W - 1 : 1;
    return idx;
  endfunction

  // Expected beats: start at sel, take max(count,1) (capped at one sweep) steps modulo OUT_W.
  task automatic build(input int sel, input int cnt, input int dir);
    int n, idx, cap;
    q.delete();
    cap = SKIP ? OUT_W - 1 : OUT_W;
    n = (cnt == 0) ? 1 : cnt;
    if (n > cap) n = cap;
    idx = fix0(sel, dir);
    for (int i = 0; i < n; i++) begin
      q.push_back(idx);
      idx = (dir != 0) ? (idx + OUT_W - 1) % OUT_W : (idx + 1) % OUT_W;
      idx = fix0(idx, dir);
    end
  endtask

  // mode 0: always ready; 1: random ready; 2: stall 3 cycles on beat 2.
  task automatic run_req(input int sel, input int cnt, input int dir, input int mode);
    int beat, stall, cyc;
    bit rdy;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_onehot", out_onehot, 0);
    in_valid  = 1'b1;
    in_sel    = SEL_W'(sel);
    in_count  = (SEL_W+1)'(cnt);
    in_dir    = dir[0];
    out_ready = 1'($urandom);
    @(negedge clk);
    build(sel, cnt, dir);
    beat = 0; stall = 0; cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      cyc++;
      chk("out_valid", out_valid, 1);
      chk("out_index", out_index, q[0]);
      chk("out_onehot", out_onehot, 32'(1) << q[0]);
      chk("out_last", out_last, (q.size() == 1) ? 1 : 0);
      chk("busy_in_ready", in_ready, 0);
      chk("busy", busy, 1);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = !(beat == 1 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      out_ready = rdy;
      // Junk requests while busy must be ignored; drop in_valid before the final transfer.
      in_valid = 1'($urandom) && !(rdy && q.size() == 1);
      in_sel   = SEL_W'($urandom);
      in_count = (SEL_W+1)'($urandom);
      in_dir   = 1'($urandom);
      @(negedge clk);
      if (rdy) begin
        void'(q.pop_front());
        beat++;
      end
    end
    chk("drained", q.size(), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    clr = 1'b0; in_valid = 1'b0; in_sel = '0; in_count = '0; in_dir = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_onehot", out_onehot, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last", out_last, 0);
    clr = 1'b1;
    @(negedge clk);

    run_req(5, 1, 0, 0);
    run_req(14, 4, 0, 0);
    run_req(2, 3, 1, 2);
    run_req(3, 0, 0, 0);
    run_req(3, 31, 0, 0);
    run_req(0, 3, 0, 0);
    run_req(0, 2, 1, 1);

    // Reset in the middle of an 8-beat sweep.
    in_valid = 1'b1; in_sel = 4'd4; in_count = 5'd8; in_dir = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_beat2_index", out_index, 5);
    clr = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_onehot", out_onehot, 0);
    chk("clr_busy", busy, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_index", out_index, 0);
    chk("clr_last", out_last, 0);
    @(negedge clk);
    chk("post_clr_no_beat", out_valid, 0);
    run_req(9, 1, 0, 0);

    repeat (40) run_req(int'($urandom_range(0, OUT_W - 1)), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 1)), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
